// File: rtl/result_reader.sv
// Drains COUNT consecutive result words from the result memory, starting at BASE_ADDR, onto a
// valid/ready stream. A small prefetch FIFO with a credit-limited read issuer absorbs backpressure.
module result_reader #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int MEM_SIZE     = 32,
  parameter int RESULT_WIDTH = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [ADDR_WIDTH:0]     count,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_read_en,
  output logic [ADDR_WIDTH-1:0]   mem_read_address,
  input  logic [DATA_WIDTH-1:0]   mem_data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RESULT_WIDTH-1:0] out_data,
  output logic                    out_last
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [OCC_W-1:0]      DEPTH_C   = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0]      OCC_ONE   = OCC_W'(1);
  localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [CNT_W-1:0]        issued_q, issued_d;
  logic [CNT_W-1:0]        elem_q, elem_d;
  logic                    done_q, done_d;
  logic                    pend_q, pend_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]        occ_q, occ_d;
  logic [RESULT_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic                    push, pop, fire;
  logic                    unused_hi_bits;

  // A read may only be issued if its return is guaranteed a FIFO slot.
  assign out_valid        = (occ_q != '0);
  assign fire             = out_valid && out_ready;
  assign out_last         = out_valid && (elem_q == count_q - CNT_ONE);
  assign out_data         = out_valid ? fifo_mem[rd_ptr_q] : '0;
  assign mem_read_address = addr_q;
  assign busy             = (state_q != IDLE);
  assign done             = done_q;
  assign push             = pend_q;
  assign pop              = fire;
  assign unused_hi_bits   = ^mem_data_in[DATA_WIDTH-1:RESULT_WIDTH];

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    issued_d    = issued_q;
    elem_d      = elem_q;
    done_d      = 1'b0;
    mem_read_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          count_d  = count;
          issued_d = '0;
          elem_d   = '0;
          if (count == '0) done_d  = 1'b1;
          else             state_d = READ;
        end
      end
      READ: begin
        if ((occ_q + OCC_W'(pend_q)) < DEPTH_C) begin
          mem_read_en = 1'b1;
          addr_d      = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_ONE;
          issued_d    = issued_q + CNT_ONE;
          if (issued_d == count_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fire && out_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fire) elem_d = elem_q + CNT_ONE;
  end

  always_comb begin
    pend_d   = mem_read_en;
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    occ_d    = occ_q;
    if (push && !pop)      occ_d = occ_q + OCC_ONE;
    else if (!push && pop) occ_d = occ_q - OCC_ONE;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      count_q  <= '0;
      issued_q <= '0;
      elem_q   <= '0;
      done_q   <= 1'b0;
      pend_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      issued_q <= issued_d;
      elem_q   <= elem_d;
      done_q   <= done_d;
      pend_q   <= pend_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // NOTE: FIFO storage is not reset; cleared pointers and the out_data gate make stale entries invisible.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_data_in[RESULT_WIDTH-1:0];
  end

endmodule
